keyframe_scheduler: RTL

- Sequences the per-frame animator. Issues one frame request (drq) per frame period and mirrors the animator's frame-time counter.
- Presents start and target keyframe times to the animator. Selects which target-keyframe buffer bank the animator reads.
- Detects when a keyframe time is reached, then swaps in the next keyframe through a one-deep prefetch register fed by a valid/ready handshake from the host loader.

---
 rtl/keyframe_scheduler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/keyframe_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : keyframe_scheduler
//  Description : Frame sequencer for the LED animator. Issues one frame
//                request per divider tick, mirrors the animator frame time,
//                and swaps keyframes through a one-deep prefetch register
//                loaded by a valid/ready handshake from the host.
//  Revision    : 1.0 - initial release
// ============================================================================
module keyframe_scheduler #(
    parameter int c_ledboards = 30,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_cnt_w     = $clog2(c_channels + 1),
    parameter int c_max_time  = 480,
    parameter int c_time_w    = $clog2(c_max_time),
    parameter int c_frame_div = 100000,
    parameter int c_div_w     = $clog2(c_frame_div)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_anim_wen,
    input  logic                i_kf_valid,
    input  logic [c_time_w-1:0] i_kf_time,
    output logic                o_kf_ready,
    output logic                o_drq,
    output logic [c_time_w-1:0] o_start_time,
    output logic [c_time_w-1:0] o_target_time,
    output logic                o_bank,
    output logic [c_time_w-1:0] o_time,
    output logic                o_busy,
    output logic                o_underrun,
    output logic                o_overrun,
    output logic                o_error
);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(c_frame_div - 1);
    localparam logic [c_time_w-1:0] c_time_last = c_time_w'(c_max_time - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(c_channels - 1);

    typedef enum logic [2:0] {
        s_load  = 3'd0,
        s_wait  = 3'd1,
        s_run   = 3'd2,
        s_check = 3'd3,
        s_hold  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_div_w-1:0]  r_div;
    logic                r_tick_pending;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_time_w-1:0] r_shadow;
    logic                r_shadow_valid;
    logic [c_time_w-1:0] r_start;
    logic [c_time_w-1:0] r_target;
    logic [c_time_w-1:0] r_time;
    logic                r_bank;
    logic                r_drq;
    logic                r_underrun;
    logic                r_overrun;
    logic                r_error;

    logic w_accept;
    logic w_kf_bad;
    logic w_wrap;
    logic w_take;
    logic w_last_wen;
    logic w_reached;
    logic w_swap;
    logic w_swap_first;
    logic w_underrun_evt;

    // Handshake qualification; a new keyframe always starts from the current target
    assign w_accept   = i_kf_valid & ~r_shadow_valid;
    assign w_kf_bad   = (32'(i_kf_time) >= 32'(c_max_time)) | (i_kf_time == r_target);
    assign w_wrap     = i_enable & (r_div == c_div_last);
    assign w_take     = (r_state == s_wait) & r_tick_pending & i_enable;
    assign w_last_wen = (r_state == s_run) & i_anim_wen & (r_cnt == c_cnt_last);
    assign w_reached  = (r_time == r_target);

    // Next-state and swap decode
    always_comb begin
        w_state_nxt    = r_state;
        w_swap         = 1'b0;
        w_swap_first   = 1'b0;
        w_underrun_evt = 1'b0;
        case (r_state)
            s_load: begin
                if (r_shadow_valid) begin
                    w_swap       = 1'b1;
                    w_swap_first = 1'b1;
                    w_state_nxt  = s_wait;
                end
            end
            s_wait: begin
                if (w_take) begin
                    w_state_nxt = s_run;
                end
            end
            s_run: begin
                if (w_last_wen) begin
                    w_state_nxt = s_check;
                end
            end
            s_check: begin
                if (!w_reached) begin
                    w_state_nxt = s_wait;
                end else if (r_shadow_valid) begin
                    w_swap      = 1'b1;
                    w_state_nxt = s_wait;
                end else begin
                    w_underrun_evt = 1'b1;
                    w_state_nxt    = s_hold;
                end
            end
            s_hold: begin
                // No frame requests here so a reached keyframe never animates over zero length
                if (r_shadow_valid) begin
                    w_swap      = 1'b1;
                    w_state_nxt = s_wait;
                end
            end
            default: w_state_nxt = s_load;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= s_load;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame-tick divider, pending tick and overrun detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div          <= '0;
            r_tick_pending <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (!i_enable) begin
                r_div <= '0;
            end else if (w_wrap) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_wrap) begin
                r_tick_pending <= 1'b1;
            end else if (w_take) begin
                r_tick_pending <= 1'b0;
            end

            if (w_wrap && r_tick_pending && !w_take) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Animator write-strobe counter, only live during a frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= '0;
        end else if ((r_state == s_run) && i_anim_wen) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Prefetch register fed by the host handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            if (w_swap) begin
                r_shadow_valid <= 1'b0;
            end else if (w_accept && !w_kf_bad) begin
                r_shadow       <= i_kf_time;
                r_shadow_valid <= 1'b1;
            end
            if (w_accept && w_kf_bad) begin
                r_error <= 1'b1;
            end
        end
    end

    // Keyframe times, bank select, frame time and frame request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start    <= '0;
            r_target   <= '0;
            r_time     <= '0;
            r_bank     <= 1'b0;
            r_drq      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_drq <= w_take;
            if (w_swap) begin
                r_start  <= w_swap_first ? '0 : r_target;
                r_target <= r_shadow;
                r_bank   <= ~r_bank;
            end
            if (w_swap_first) begin
                r_time <= '0;
            end else if (w_take) begin
                r_time <= (r_time == c_time_last) ? '0 : r_time + 1'b1;
            end
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign o_kf_ready    = ~r_shadow_valid;
    assign o_drq         = r_drq;
    assign o_start_time  = r_start;
    assign o_target_time = r_target;
    assign o_bank        = r_bank;
    assign o_time        = r_time;
    assign o_busy        = (r_state == s_run);
    assign o_underrun    = r_underrun;
    assign o_overrun     = r_overrun;
    assign o_error       = r_error;

endmodule
`default_nettype wire
